// File: rtl/fetch_mem_unit.sv
// PC/IR/MDR datapath for the multicycle core. Bridges control-side memory
// strobes onto a variable-latency req/ready memory and stalls control while an access is pending.
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        Cond,
    input  logic [1:0]  PCSource,
    input  logic        IRWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IorD,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        zero,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        err_timeout,
    output logic        err_illegal
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_r, state_s;
    logic [31:0]   addr_r, wdata_r;
    logic          we_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   pc_r, ir_r, mdr_r;
    logic          err_timeout_r, err_illegal_r;

    logic          req_s, we_s, done_s, stall_s, take_s;
    logic [31:0]   addr_s, wdata_s, pc_next_s;

    // Memory-side request selection and FSM next state.
    always_comb begin
        state_s = state_r;
        req_s   = 1'b0;
        we_s    = 1'b0;
        addr_s  = 32'h0000_0000;
        wdata_s = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                req_s   = MemRead | MemWrite;
                we_s    = MemWrite;
                addr_s  = (IorD ? alu_out : pc_r) & 32'hFFFF_FFFC;
                wdata_s = store_data;
                if (req_s && !mem_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // Captured request is replayed; control inputs are ignored until completion.
                req_s   = 1'b1;
                we_s    = we_r;
                addr_s  = addr_r;
                wdata_s = wdata_r;
                if (mem_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign stall_s = req_s & ~mem_ready;
    assign done_s  = req_s & mem_ready;
    assign take_s  = PCWrite | (Branch & (zero ^ Cond));

    // PC source mux.
    always_comb begin
        pc_next_s = pc_r;
        case (PCSource)
            2'b00:   pc_next_s = alu_result;
            2'b01:   pc_next_s = alu_out;
            2'b10:   pc_next_s = {pc_r[31:28], ir_r[25:0], 2'b00};
            2'b11:   pc_next_s = pc_r;
            default: pc_next_s = pc_r;
        endcase
    end

    // State, captured request, wait counter, architectural registers and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            addr_r        <= 32'h0000_0000;
            wdata_r       <= 32'h0000_0000;
            we_r          <= 1'b0;
            cnt_r         <= '0;
            pc_r          <= RESET_PC;
            ir_r          <= 32'h0000_0000;
            mdr_r         <= 32'h0000_0000;
            err_timeout_r <= 1'b0;
            err_illegal_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE) begin
                addr_r  <= addr_s;
                wdata_r <= wdata_s;
                we_r    <= we_s;
                cnt_r   <= '0;
            end else if (stall_s) begin
                if (cnt_r != CW'(TIMEOUT)) begin
                    cnt_r <= cnt_r + CW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
                // The initial IDLE stall plus TIMEOUT waiting cycles exceeds the limit.
                if (cnt_r == CW'(TIMEOUT - 1)) begin
                    err_timeout_r <= 1'b1;
                end else begin
                    err_timeout_r <= err_timeout_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
            if (done_s && !we_s) begin
                mdr_r <= mem_rdata;
                if (IRWrite) begin
                    ir_r <= mem_rdata;
                end else begin
                    ir_r <= ir_r;
                end
            end else begin
                mdr_r <= mdr_r;
            end
            if (take_s && !stall_s) begin
                pc_r <= pc_next_s;
            end else begin
                pc_r <= pc_r;
            end
            if (MemRead && MemWrite) begin
                err_illegal_r <= 1'b1;
            end else begin
                err_illegal_r <= err_illegal_r;
            end
        end
    end

    assign mem_req     = req_s;
    assign mem_we      = we_s;
    assign mem_addr    = addr_s;
    assign mem_wdata   = wdata_s;
    assign stall       = stall_s;
    assign pc          = pc_r;
    assign ir          = ir_r;
    assign opcode      = ir_r[31:26];
    assign mdr         = mdr_r;
    assign err_timeout = err_timeout_r;
    assign err_illegal = err_illegal_r;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed self-checking bench for fetch_mem_unit: fetches, branches, jump,
// loads/stores with wait states, timeout boundary, illegal strobe and reset during a wait.
module tb_fetch_mem_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, Branch, Cond, IRWrite, MemRead, MemWrite, IorD, zero, mem_ready;
    logic [1:0]  PCSource;
    logic [31:0] alu_result, alu_out, store_data, mem_rdata;
    logic        mem_req, mem_we, stall, err_timeout, err_illegal;
    logic [31:0] mem_addr, mem_wdata, pc, ir, mdr;
    logic [5:0]  opcode;

    int checks = 0;
    int errors = 0;

    fetch_mem_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Cond(Cond),
        .PCSource(PCSource), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .alu_result(alu_result), .alu_out(alu_out), .zero(zero),
        .store_data(store_data), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc(pc), .ir(ir), .opcode(opcode), .mdr(mdr), .stall(stall),
        .err_timeout(err_timeout), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl;
        PCWrite = 1'b0; Branch = 1'b0; Cond = 1'b0; PCSource = 2'b00; IRWrite = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    endtask

    // Store of 'stalls' wait cycles followed by completion; checks held request fields.
    task automatic store_with_wait(input int stalls, input logic [31:0] addr, input logic [31:0] data);
        idle_ctl();
        MemWrite = 1'b1; IorD = 1'b1; alu_out = addr; store_data = data;
        for (int i = 0; i < stalls; i++) begin
            #1;
            check("st_stall", stall, 1'b1);
            check("st_we", mem_we, 1'b1);
            check("st_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("st_wdata", mem_wdata, data);
            step();
            store_data = 32'h0BAD_0BAD;
            alu_out    = 32'h0000_0FF0;
        end
        mem_ready = 1'b1;
        #1;
        check("st_done_stall", stall, 1'b0);
        step();
        idle_ctl();
    endtask

    initial begin
        idle_ctl();
        rst = 1'b1; alu_result = 32'h0; alu_out = 32'h0; store_data = 32'h0; mem_rdata = 32'h0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_mdr", mdr, 32'h0);
        check("rst_req", mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_errs", {err_timeout, err_illegal}, 2'b00);

        // Zero-wait fetch
        MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 32'h4;
        mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        #1;
        check("zw_req", mem_req, 1'b1);
        check("zw_stall", stall, 1'b0);
        check("zw_addr", mem_addr, 32'h0);
        step();
        idle_ctl();
        check("zw_pc", pc, 32'h4);
        check("zw_ir", ir, 32'h2008_0005);
        check("zw_opcode", opcode, 6'h08);
        check("zw_mdr", mdr, 32'h2008_0005);

        // 3-wait fetch from pc=4
        MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 32'h8;
        mem_rdata = 32'h0800_0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("w3_stall", stall, 1'b1);
            check("w3_addr", mem_addr, 32'h4);
            check("w3_pc", pc, 32'h4);
            step();
            IorD = 1'b1; alu_out = 32'h0000_0200;
        end
        mem_ready = 1'b1;
        #1;
        check("w3_done_stall", stall, 1'b0);
        check("w3_done_addr", mem_addr, 32'h4);
        step();
        idle_ctl();
        check("w3_pc_after", pc, 32'h8);
        check("w3_ir", ir, 32'h0800_0010);

        // Jump: pc=1000_0004, ir=0800_0010
        PCWrite = 1'b1; PCSource = 2'b00; alu_result = 32'h1000_0004;
        step();
        PCSource = 2'b10;
        step();
        idle_ctl();
        check("jump_pc", pc, 32'h1000_0040);

        // beq / bne
        Branch = 1'b1; Cond = 1'b0; PCSource = 2'b01; alu_out = 32'h40; zero = 1'b1;
        step();
        check("beq_taken", pc, 32'h40);
        alu_out = 32'h80; zero = 1'b0;
        step();
        check("beq_not", pc, 32'h40);
        Cond = 1'b1; zero = 1'b0;
        step();
        check("bne_taken", pc, 32'h80);
        zero = 1'b1; alu_out = 32'hC0;
        step();
        check("bne_not", pc, 32'h80);
        idle_ctl();
        PCWrite = 1'b1; PCSource = 2'b11; alu_result = 32'h1234;
        step();
        check("src11_hold", pc, 32'h80);

        // IRWrite without a completed read
        idle_ctl();
        IRWrite = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
        step();
        check("irw_nodone_ir", ir, 32'h0800_0010);
        check("irw_nodone_mdr", mdr, 32'h0800_0010);

        // lw, misaligned address
        idle_ctl();
        MemRead = 1'b1; IorD = 1'b1; alu_out = 32'h103; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("lw_addr", mem_addr, 32'h100);
        check("lw_we", mem_we, 1'b0);
        step();
        idle_ctl();
        check("lw_mdr", mdr, 32'hDEAD_BEEF);
        check("lw_ir", ir, 32'h0800_0010);
        check("lw_pc", pc, 32'h80);

        // sw with exactly TIMEOUT stall cycles: no error
        store_with_wait(TO, 32'h204, 32'hCAFE_F00D);
        check("sw_to_edge", err_timeout, 1'b0);
        check("sw_mdr", mdr, 32'hDEAD_BEEF);

        // sw with TIMEOUT+1 stall cycles: sticky error
        store_with_wait(TO + 1, 32'h208, 32'h1111_2222);
        check("sw_to_err", err_timeout, 1'b1);
        step(); step();
        check("sw_to_sticky", err_timeout, 1'b1);

        // Read and write strobes together
        MemRead = 1'b1; MemWrite = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("ill_we", mem_we, 1'b1);
        step();
        idle_ctl();
        check("ill_err", err_illegal, 1'b1);
        check("ill_mdr", mdr, 32'hDEAD_BEEF);

        // Reset on second stall cycle of a fetch
        MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 32'h84;
        step();
        #1;
        check("rw_stall2", stall, 1'b1);
        rst = 1'b1;
        idle_ctl();
        step();
        check("rw_req", mem_req, 1'b0);
        check("rw_stall", stall, 1'b0);
        check("rw_pc", pc, 32'h0);
        check("rw_ir", ir, 32'h0);
        check("rw_mdr", mdr, 32'h0);
        check("rw_errs", {err_timeout, err_illegal}, 2'b00);
        rst = 1'b0;
        mem_ready = 1'b1;
        step();
        check("rw_idle_req", mem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
